// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a single external memory bus.
// Data has priority over fetch, bounded by a starvation counter; ACCESS waits are bounded by TIMEOUT.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_req,
    input  logic [7:0] f_addr,
    output logic       f_gnt,
    output logic       f_rvalid,
    output logic [7:0] f_rdata,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [7:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_gnt,
    output logic       d_rvalid,
    output logic [7:0] d_rdata,
    output logic       mem_valid,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic       bus_err,
    output logic       busy
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          sel_data_q, sel_data_d;
    logic          f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
    logic          f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [7:0]    f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
    logic          mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
    logic [7:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic          bus_err_q, bus_err_d, busy_q, busy_d;

    logic any_req, grant_f, grant_d, starved, timed_out;

    assign any_req   = f_req | d_req;
    assign starved   = (starve_q == SW'(STARVE_LIMIT));
    assign grant_f   = f_req & (~d_req | starved);
    assign grant_d   = d_req & ~grant_f;
    assign timed_out = (wait_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (mem_ready || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d    = starve_q;
        wait_d      = wait_q;
        sel_data_d  = sel_data_q;
        f_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        f_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        bus_err_d   = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_valid_d = (state_d == ACCESS);
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_data_d = grant_d;
                    wait_d     = '0;
                    if (grant_d) begin
                        d_gnt_d     = 1'b1;
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                        // Only data grants that bypass a waiting fetch count toward starvation.
                        if (f_req && !starved) starve_d = starve_q + SW'(1);
                    end else begin
                        f_gnt_d     = 1'b1;
                        mem_addr_d  = f_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready || timed_out) begin
                    bus_err_d = ~mem_ready;
                    if (sel_data_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_ready ? mem_rdata : '0;
                    end else begin
                        f_rvalid_d = 1'b1;
                        f_rdata_d  = mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            wait_q      <= '0;
            sel_data_q  <= 1'b0;
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            sel_data_q  <= sel_data_d;
            f_gnt_q     <= f_gnt_d;
            d_gnt_q     <= d_gnt_d;
            f_rvalid_q  <= f_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
            busy_q      <= busy_d;
        end
    end

    assign f_gnt     = f_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign f_rvalid  = f_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned TIMEOUT      = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic       f_gnt, f_rvalid, d_gnt, d_rvalid, mem_valid, mem_we, bus_err, busy;
    logic [7:0] f_rdata, d_rdata, mem_addr, mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: transaction-level view of the arbiter.
    bit         m_in_access, m_in_resp, m_data_winner;
    int         m_access_cycles, m_streak;
    logic       e_f_gnt, e_d_gnt, e_f_rvalid, e_d_rvalid, e_mem_valid, e_we, e_err, e_busy;
    logic [7:0] e_f_rdata, e_d_rdata, e_addr, e_wdata;

    task automatic model_reset();
        m_in_access = 0; m_in_resp = 0; m_data_winner = 0; m_access_cycles = 0; m_streak = 0;
        {e_f_gnt, e_d_gnt, e_f_rvalid, e_d_rvalid, e_mem_valid, e_we, e_err, e_busy} = '0;
        {e_f_rdata, e_d_rdata, e_addr, e_wdata} = '0;
    endtask

    task automatic model_step();
        logic [7:0] v;
        e_f_gnt = 0; e_d_gnt = 0; e_f_rvalid = 0; e_d_rvalid = 0; e_err = 0;
        if (m_in_resp) begin
            m_in_resp = 0;
        end else if (m_in_access) begin
            m_access_cycles++;
            if (mem_ready || m_access_cycles == TIMEOUT) begin
                v = mem_ready ? mem_rdata : 8'h00;
                if (m_data_winner) begin e_d_rvalid = 1; e_d_rdata = v; end
                else begin e_f_rvalid = 1; e_f_rdata = v; end
                e_err = !mem_ready;
                m_in_access = 0;
                m_in_resp = 1;
            end
        end else if (f_req || d_req) begin
            m_data_winner = d_req && !(f_req && m_streak == STARVE_LIMIT);
            if (m_data_winner) begin
                e_d_gnt = 1; e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
                if (f_req && m_streak < STARVE_LIMIT) m_streak++;
            end else begin
                e_f_gnt = 1; e_addr = f_addr; e_we = 0; e_wdata = 8'h00;
                m_streak = 0;
            end
            m_in_access = 1;
            m_access_cycles = 0;
        end
        e_mem_valid = m_in_access;
        e_busy = m_in_access || m_in_resp;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1; f_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        vectors++;
        if ({f_gnt, f_rvalid, d_gnt, d_rvalid, mem_valid, mem_we, bus_err, busy} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {f_gnt, f_rvalid, d_gnt, d_rvalid, mem_valid, mem_we, bus_err, busy});
        end
        vectors++;
        if ({f_rdata, d_rdata, mem_addr, mem_wdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 00000000", {f_rdata, d_rdata, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 8'h20; mem_ready = 0;
        @(negedge clk);
        d_req = 0;
        vectors++;
        if ({d_gnt, f_gnt, mem_valid, mem_we, mem_addr, busy} !== {4'b1010, 8'h20, 1'b1}) begin
            miscompares++;
            $display("FAIL read_grant: got gnt=%b fgnt=%b mv=%b we=%b addr=%h busy=%b want 1 0 1 0 20 1",
                     d_gnt, f_gnt, mem_valid, mem_we, mem_addr, busy);
        end
        @(negedge clk);
        vectors++;
        if ({d_gnt, mem_valid, d_rvalid} !== 3'b010) begin
            miscompares++;
            $display("FAIL read_wait: got gnt=%b mv=%b rvalid=%b want 0 1 0", d_gnt, mem_valid, d_rvalid);
        end
        mem_ready = 1; mem_rdata = 8'hA5;
        @(negedge clk);
        mem_ready = 0;
        vectors++;
        if ({d_rvalid, f_rvalid, bus_err, mem_valid, d_rdata} !== {4'b1000, 8'hA5}) begin
            miscompares++;
            $display("FAIL read_resp: got rv=%b frv=%b err=%b mv=%b rdata=%h want 1 0 0 0 a5",
                     d_rvalid, f_rvalid, bus_err, mem_valid, d_rdata);
        end
        @(negedge clk);
        vectors++;
        if ({d_rvalid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_idle: got rv=%b busy=%b want 0 0", d_rvalid, busy);
        end
    endtask

    task automatic test_starvation();
        string order = "";
        int grants = 0;
        apply_reset();
        f_req = 1; d_req = 1; d_we = 0; mem_ready = 1; mem_rdata = 8'h77;
        for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
            @(negedge clk);
            vectors++;
            if (f_gnt && d_gnt) begin
                miscompares++;
                $display("FAIL starve_dual_gnt: got f_gnt=1 d_gnt=1 want at most one");
            end
            if (d_gnt) begin order = {order, "D"}; grants++; end
            else if (f_gnt) begin order = {order, "F"}; grants++; end
        end
        f_req = 0; d_req = 0;
        vectors++;
        if (order != "DDDDFDDDDF") begin
            miscompares++;
            $display("FAIL starve_order: got %s want DDDDFDDDDF", order);
        end
        for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_drain: got busy=%b want 0", busy);
        end
        mem_ready = 0;
    endtask

    task automatic test_timeout_write();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 8'h3C; mem_ready = 0;
        @(negedge clk);
        d_req = 0;
        vectors++;
        if (d_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_grant: got d_gnt=%b want 1", d_gnt);
        end
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({mem_valid, mem_we, mem_wdata, mem_addr, d_rvalid} !== {2'b11, 8'h3C, 8'h10, 1'b0}) begin
                miscompares++;
                $display("FAIL tmo_access[%0d]: got mv=%b we=%b wd=%h addr=%h rv=%b want 1 1 3c 10 0",
                         i, mem_valid, mem_we, mem_wdata, mem_addr, d_rvalid);
            end
        end
        @(negedge clk);
        vectors++;
        if ({d_rvalid, bus_err, mem_valid, d_rdata} !== {3'b110, 8'h00}) begin
            miscompares++;
            $display("FAIL tmo_resp: got rv=%b err=%b mv=%b rdata=%h want 1 1 0 00",
                     d_rvalid, bus_err, mem_valid, d_rdata);
        end
        @(negedge clk);
        vectors++;
        if ({d_rvalid, bus_err, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL tmo_idle: got rv=%b err=%b busy=%b want 0 0 0", d_rvalid, bus_err, busy);
        end
    endtask

    task automatic test_ready_on_timeout();
        @(negedge clk);
        f_req = 1; f_addr = 8'h5F; mem_ready = 0; mem_rdata = 8'h5A;
        @(negedge clk);
        f_req = 0;
        vectors++;
        if ({f_gnt, mem_we, mem_wdata, mem_addr} !== {2'b10, 8'h00, 8'h5F}) begin
            miscompares++;
            $display("FAIL late_grant: got gnt=%b we=%b wd=%h addr=%h want 1 0 00 5f",
                     f_gnt, mem_we, mem_wdata, mem_addr);
        end
        repeat (TIMEOUT - 1) @(negedge clk);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        vectors++;
        if ({f_rvalid, d_rvalid, bus_err, f_rdata, d_rdata} !== {3'b100, 8'h5A, 8'h00}) begin
            miscompares++;
            $display("FAIL late_resp: got frv=%b drv=%b err=%b frd=%h drd=%h want 1 0 0 5a 00",
                     f_rvalid, d_rvalid, bus_err, f_rdata, d_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        f_req = 1; f_addr = 8'h44; mem_ready = 0;
        @(negedge clk);
        vectors++;
        if ({f_gnt, mem_valid, mem_addr} !== {2'b11, 8'h44}) begin
            miscompares++;
            $display("FAIL rstmid_grant: got gnt=%b mv=%b addr=%h want 1 1 44", f_gnt, mem_valid, mem_addr);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if ({mem_valid, busy, f_gnt, mem_addr} !== 11'h0) begin
            miscompares++;
            $display("FAIL rstmid_async: got mv=%b busy=%b gnt=%b addr=%h want 0 0 0 00",
                     mem_valid, busy, f_gnt, mem_addr);
        end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({f_rvalid, f_gnt, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_hold: got rv=%b gnt=%b busy=%b want 0 0 0", f_rvalid, f_gnt, busy);
            end
        end
        rst = 0;
        @(negedge clk);
        f_req = 0;
        vectors++;
        if ({f_gnt, mem_valid, mem_addr} !== {2'b11, 8'h44}) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got gnt=%b mv=%b addr=%h want 1 1 44", f_gnt, mem_valid, mem_addr);
        end
        mem_ready = 1; mem_rdata = 8'hC3;
        @(negedge clk);
        mem_ready = 0;
        vectors++;
        if ({f_rvalid, f_rdata} !== {1'b1, 8'hC3}) begin
            miscompares++;
            $display("FAIL rstmid_resp: got rv=%b rdata=%h want 1 c3", f_rvalid, f_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [39:0] got, exp;
        int ready_pct = 50;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) ready_pct = (($urandom_range(0, 3)) == 0) ? 2 : int'($urandom_range(20, 90));
            f_req     = ($urandom_range(0, 99) < 60);
            d_req     = ($urandom_range(0, 99) < 70);
            d_we      = $urandom_range(0, 1);
            f_addr    = 8'($urandom);
            d_addr    = 8'($urandom);
            d_wdata   = 8'($urandom);
            mem_rdata = 8'($urandom);
            mem_ready = ($urandom_range(0, 99) < ready_pct);
            model_step();
            @(negedge clk);
            got = {f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
                   mem_valid, mem_we, mem_addr, mem_wdata, bus_err, busy};
            exp = {e_f_gnt, e_f_rvalid, e_f_rdata, e_d_gnt, e_d_rvalid, e_d_rdata,
                   e_mem_valid, e_we, e_addr, e_wdata, e_err, e_busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h (fg,frv,frd,dg,drv,drd,mv,we,addr,wd,err,busy)",
                         cyc, got, exp);
            end
        end
        f_req = 0; d_req = 0; mem_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_starvation();
        test_timeout_write();
        test_ready_on_timeout();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
